// File: rtl/mult_div.sv
// mult_div: multi-cycle HI/LO multiply/divide unit.
//   MULT/MULTU finish in MUL_CYCLES cycles, DIV/DIVU run a 32-step restoring
//   divider on operand magnitudes with a final sign fix-up.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start, op[1:0]   launch (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), IDLE only
//   A, B [31:0]      multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we     MTHI/MTLO strobes with wdata[31:0], IDLE and no start only
//   busy             high while an operation runs
//   done             one-cycle pulse after HI/LO were written by an operation
//   hi, lo [31:0]    HI/LO registers
module mult_div #(
  parameter int MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  // Control state
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand / divider datapath state (not reset; only read while busy)
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dvz_q, dvz_d;

  logic               accept;
  logic signed [63:0] mul_a_s, mul_b_s, prod_s;
  logic [32:0]        shl, sub;
  logic               ge;
  logic [31:0]        rem_n, quo_n, div_hi, div_lo;

  assign accept = (state_q == S_IDLE) && start;

  // Datapath: 64x64 signed product of extended operands gives the exact low
  // 64 bits for both signed and unsigned forms.
  always_comb begin
    mul_a_s = {{32{a_q[31] & sgn_q}}, a_q};
    mul_b_s = {{32{b_q[31] & sgn_q}}, b_q};
    prod_s  = mul_a_s * mul_b_s;

    // Restoring step: partial remainder is always < divisor, so bit 32 of
    // the difference is a clean borrow flag.
    shl   = {rem_q, quo_q[31]};
    sub   = shl - {1'b0, dvs_q};
    ge    = ~sub[32];
    rem_n = ge ? sub[31:0] : shl[31:0];
    quo_n = {quo_q[30:0], ge};

    div_lo = dvz_q ? 32'hFFFF_FFFF : neg_if(quo_n, qneg_q);
    div_hi = dvz_q ? a_q           : neg_if(rem_n, rneg_q);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sgn_d  = sgn_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dvz_d  = dvz_q;
    if (accept) begin
      a_d    = A;
      b_d    = B;
      sgn_d  = ~op[0];
      rem_d  = 32'd0;
      quo_d  = neg_if(A, ~op[0] & A[31]);
      dvs_d  = neg_if(B, ~op[0] & B[31]);
      qneg_d = ~op[0] & (A[31] ^ B[31]);
      rneg_d = ~op[0] & A[31];
      dvz_d  = (B == 32'd0);
    end else if (state_q == S_DIV) begin
      rem_d = rem_n;
      quo_d = quo_n;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = op[1] ? S_DIV : S_MUL;
          cnt_d   = 6'd0;
          busy_d  = 1'b1;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == MUL_LAST) begin
          hi_d    = prod_s[63:32];
          lo_d    = prod_s[31:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = 6'd0;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == DIV_LAST) begin
          hi_d    = div_hi;
          lo_d    = div_lo;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = 6'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    sgn_q  <= sgn_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
    dvz_q  <= dvz_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, busy cycles per MULT/MULTU (legal 1..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  launch operation selected by op.
REQ-005 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port A  input  32  multiplicand / dividend (rs).
REQ-007 SHALL have port B  input  32  multiplier / divisor (rt).
REQ-008 SHALL have port hi_we  input  1  MTHI write strobe.
REQ-009 SHALL have port lo_we  input  1  MTLO write strobe.
REQ-010 SHALL have port wdata  input  32  MTHI/MTLO data.
REQ-011 SHALL have port busy  output  1  operation in progress; pipeline stalls MFHI/MFLO/new MULT/DIV while high.
REQ-012 SHALL have port done  output  1  one-cycle pulse, HI/LO just updated by an operation.
REQ-013 SHALL have port hi  output  32  HI register.
REQ-014 SHALL have port lo  output  32  LO register.

Function
REQ-015 SHALL implement FSM IDLE, MUL, DIV; busy=1 exactly in MUL and DIV.
REQ-016 SHALL accept start only in IDLE; A, B, op captured at accepting edge t; later changes to A/B/op have no effect.
REQ-017 SHALL ignore start while busy=1 (no restart, no queuing).
REQ-018 SHALL, for MULT/MULTU, hold busy high cycles t+1..t+MUL_CYCLES, write {hi,lo}=64-bit product at edge t+MUL_CYCLES, return to IDLE same edge.
REQ-019 SHALL, for DIV/DIVU, run 32 iterations, busy high cycles t+1..t+32, write lo=quotient, hi=remainder at edge t+32, return to IDLE.
REQ-020 SHALL treat operands as two's complement for MULT/DIV, unsigned for MULTU/DIVU.
REQ-021 SHALL truncate signed quotient toward zero; remainder takes sign of dividend; |remainder|<|divisor|.
REQ-022 SHALL on divisor 0 (either divide): full 32-cycle latency, lo=32'hFFFFFFFF, hi=A.
REQ-023 SHALL on DIV 0x80000000 / 0xFFFFFFFF: lo=32'h80000000, hi=0.
REQ-024 SHALL pulse done for the one cycle following the result-writing edge; done=0 otherwise.
REQ-025 SHALL apply hi_we/lo_we only in IDLE with start=0; hi_we/lo_we independent, both may write same edge.
REQ-026 SHALL ignore hi_we/lo_we while busy=1 or when start accepted same edge (start wins).
REQ-027 SHALL keep hi/lo stable during MUL/DIV; intermediate values never visible on hi/lo.
REQ-028 SHALL allow a new start in the cycle done=1 (FSM already IDLE).

Reset
REQ-029 SHALL on rst=1, immediately and regardless of clk: state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter 0.
REQ-030 SHALL abort any in-flight operation on reset; no result written after rst deasserts.
REQ-031 SHALL ignore start, hi_we, lo_we while rst=1.

Verification
REQ-032 SHALL test MULT A=32'hFFFFFFFD, B=7, MUL_CYCLES=5 -> busy 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, done one cycle.
REQ-033 SHALL test MULTU A=B=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-034 SHALL test DIV A=32'hFFFFFFF9 (-7), B=2 -> busy 32 cycles, lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU same operands -> lo=32'h7FFFFFFC, hi=1.
REQ-035 SHALL test DIVU A=32'h12345678, B=0 -> after 32 cycles lo=32'hFFFFFFFF, hi=32'h12345678; DIV 0x80000000/-1 -> lo=32'h80000000, hi=0.
REQ-036 SHALL test start and hi_we asserted mid-DIV, plus MTLO wdata=32'hA5A5A5A5 in IDLE -> mid-op requests ignored, lo=32'hA5A5A5A5 next edge.
REQ-037 SHALL test rst pulsed (off clock edge) at DIV cycle 10 -> busy, hi, lo 0 immediately; no done pulse; next start runs normally.
